path_metric_acs: RTL and testbench
==================================

PATH_METRIC_ACS -- requirements
Module: path_metric_acs

Interface
REQ-001 Parameter K, default 3: convolutional constraint length; number of states N = 2^(K-1); legal range 3..9.
REQ-002 Parameter BM_W, default 2: branch-metric width in bits.
REQ-003 Parameter PM_W, default 8: path-metric width in bits; must exceed BM_W+1.
REQ-004 Parameter DEPTH, default 64: survivor frame depth in symbols; power of two, at least 4.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 flush  in  1  synchronous frame restart.
REQ-008 in_valid  in  1  branch-metric vector valid this cycle.
REQ-009 bm  in  N*2*BM_W  branch metrics; field (2j+b) is the metric from predecessor ((2j) mod N)|b into state j.
REQ-010 surv_valid  out  1  survivor vector valid.
REQ-011 surv  out  N  survivor decisions; bit j = b of the chosen predecessor of state j.
REQ-012 mem_address  out  log2(DEPTH)  survivor-memory write address paired with surv.
REQ-013 frame_end  out  1  surv holds the last symbol of a frame.
REQ-014 best_valid  out  1  one-cycle pulse; best_idx updated.
REQ-015 best_idx  out  K-1  index of the minimum path metric at frame end.

Function
REQ-016 On an in_valid cycle, for every state j the block SHALL form c_b = PM[((2j) mod N)|b] + bm[2j+b] at PM_W+1 bits for b in {0,1}, select the smaller, and register it as the new PM[j].
REQ-017 On a tie (c_0 == c_1) the block SHALL select b=0.
REQ-018 All N ACS updates SHALL occur in the same cycle, using only the previous PM values.
REQ-019 surv, surv_valid, mem_address and frame_end SHALL be registered one cycle after the accepting in_valid cycle (latency 1).
REQ-020 The block SHALL always accept input; there is no backpressure.
REQ-021 surv_valid SHALL be low in every cycle that does not follow an accepted symbol, and surv SHALL hold its last value during those cycles.
REQ-022 The address counter SHALL start at 0, increment per accepted symbol, and wrap from DEPTH-1 to 0.
REQ-023 frame_end SHALL be 1 exactly when the output mem_address equals DEPTH-1.
REQ-024 In the cycle after frame_end, best_valid SHALL pulse for one cycle with best_idx = the argmin over the registered PMs.
REQ-025 For the argmin, the lowest index SHALL win ties.
REQ-026 best_idx SHALL hold its value until the next best_valid pulse.
REQ-027 flush SHALL reinitialise the PMs (per REQ-031) and the address counter to 0, clear surv_valid, frame_end and best_valid, and drop any in_valid in the same cycle; flush SHALL have priority over in_valid.
REQ-028 A flush in the cycle in which best_valid would fire SHALL suppress that pulse.

Reset
REQ-029 When rst is high, the block SHALL apply the same effect as flush.
REQ-030 When rst is high, the block SHALL set surv=0, mem_address=0 and best_idx=0.
REQ-031 At reset or flush, PM[0] SHALL be 0 and PM[j>0] SHALL be 2^(PM_W-2), reflecting a known all-zero start state.
REQ-032 rst SHALL take priority over flush and in_valid.

Configuration
REQ-033 The feature is controlled by the macro PM_RENORM_EN.
REQ-034 With PM_RENORM_EN defined: after the ACS update, if every new PM has its MSB set, the block SHALL clear the MSB of all PMs in the same register write (subtract 2^(PM_W-1)).
REQ-035 With PM_RENORM_EN undefined: each new PM SHALL saturate at 2^PM_W-1 and no renormalisation SHALL occur.
REQ-036 Survivor decisions SHALL be computed before renormalisation or saturation.

Structure
REQ-037 A shared package viterbi_pkg SHALL hold the default K, BM_W, PM_W and DEPTH values and the function computing the predecessor index.
REQ-038 The argmin SHALL be a sub-module pm_argmin: a parametrised N-input comparator tree, purely combinational, lowest index on ties.
REQ-039 The ACS array SHALL be a generate loop inside path_metric_acs.

Verification (K=3, BM_W=2, PM_W=8, DEPTH=8)
REQ-040 Reset scenario: pulse rst for 1 cycle -> PM={0,64,64,64}, surv_valid=0, mem_address=0, best_idx=0.
REQ-041 Single ACS scenario: one in_valid with bm[0]=2, bm[1]=0 -> PM[0]=2 (0+2 < 64+0), surv[0]=0, surv_valid=1 on the next cycle only.
REQ-042 Frame scenario: 8 symbols of all-zero bm -> mem_address 0..7, frame_end with address 7, best_valid pulse next cycle with best_idx=0; a 9th symbol gives address 0.
REQ-043 Renorm/saturation scenario: drive bm=3 until all PMs >= 128 -> with PM_RENORM_EN all PMs drop by 128 in one cycle; without it, PMs cap at 255.
REQ-044 Flush scenario: flush together with in_valid at address 3 -> symbol dropped, surv_valid=0, next accepted symbol at address 0, PMs reinitialised.
REQ-045 Tie scenario: c_0 == c_1 -> surv bit 0; equal PMs at frame end -> lowest best_idx.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder defaults and trellis helpers.
// Consumers: path_metric_acs, pm_argmin.
package viterbi_pkg;

    localparam int K_DEF     = 3;
    localparam int BM_W_DEF  = 2;
    localparam int PM_W_DEF  = 8;
    localparam int DEPTH_DEF = 64;

    // Predecessor of state j on branch b in a shift-register trellis
    function automatic int pred_idx(input int j, input int b, input int n);
        return ((2 * j) % n) | b;
    endfunction

endpackage

// File: rtl/pm_argmin.sv
// Combinational N-input min-index comparator tree.
// Equal values resolve to the lower index.
module pm_argmin #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic [N*W-1:0]       vals,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [W-1:0]  v  [IW+1][N];
    logic [IW-1:0] ix [IW+1][N];

    always_comb begin
        for (int l = 0; l <= IW; l++) begin
            for (int k = 0; k < N; k++) begin
                v[l][k]  = '0;
                ix[l][k] = '0;
            end
        end
        for (int k = 0; k < N; k++) begin
            v[0][k]  = vals[k*W +: W];
            ix[0][k] = IW'(k);
        end
        // Right child only wins when strictly smaller
        for (int l = 1; l <= IW; l++) begin
            for (int k = 0; k < (N >> l); k++) begin
                if (v[l-1][2*k+1] < v[l-1][2*k]) begin
                    v[l][k]  = v[l-1][2*k+1];
                    ix[l][k] = ix[l-1][2*k+1];
                end else begin
                    v[l][k]  = v[l-1][2*k];
                    ix[l][k] = ix[l-1][2*k];
                end
            end
        end
    end

    assign idx = ix[IW][0];

endmodule

// File: rtl/path_metric_acs.sv
// Viterbi add-compare-select array with survivor output and frame-end argmin.
// Define PM_RENORM_EN for MSB renormalisation instead of saturation.
module path_metric_acs
    import viterbi_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int BM_W  = BM_W_DEF,
    parameter int PM_W  = PM_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in_valid,
    input  logic [(1<<(K-1))*2*BM_W-1:0]    bm,
    output logic                            surv_valid,
    output logic [(1<<(K-1))-1:0]           surv,
    output logic [$clog2(DEPTH)-1:0]        mem_address,
    output logic                            frame_end,
    output logic                            best_valid,
    output logic [K-2:0]                    best_idx
);

    localparam int N   = 1 << (K - 1);
    localparam int AW  = $clog2(DEPTH);
    localparam int C_W = PM_W + 1;
    localparam logic [PM_W-1:0] PM_INIT = PM_W'(1 << (PM_W - 2));

    logic [N-1:0][PM_W-1:0] pm_q;
    logic [N-1:0][PM_W-1:0] pm_d;
    logic [N-1:0]           dec;
    logic [AW-1:0]          wr_ptr;
    logic [K-2:0]           arg_idx;

    // State 0 is the known start state
    function automatic logic [N-1:0][PM_W-1:0] pm_init();
        logic [N-1:0][PM_W-1:0] r;
        for (int j = 0; j < N; j++) begin
            r[j] = (j == 0) ? '0 : PM_INIT;
        end
        return r;
    endfunction

`ifdef PM_RENORM_EN
    logic [N-1:0] msb;
    logic         all_msb;
    assign all_msb = &msb;
`endif

    for (genvar j = 0; j < N; j++) begin : g_acs
        localparam int P0 = pred_idx(j, 0, N);
        localparam int P1 = pred_idx(j, 1, N);
        logic [C_W-1:0] c0;
        logic [C_W-1:0] c1;
        logic [C_W-1:0] win;

        assign c0 = {1'b0, pm_q[P0]} + C_W'(bm[(2*j)*BM_W +: BM_W]);
        assign c1 = {1'b0, pm_q[P1]} + C_W'(bm[(2*j+1)*BM_W +: BM_W]);
        assign dec[j] = c1 < c0;
        assign win = dec[j] ? c1 : c0;
`ifdef PM_RENORM_EN
        assign msb[j] = win[PM_W-1];
        assign pm_d[j] = all_msb ? {1'b0, win[PM_W-2:0]} : win[PM_W-1:0];
`else
        assign pm_d[j] = win[PM_W] ? '1 : win[PM_W-1:0];
`endif
    end

    pm_argmin #(
        .N (N),
        .W (PM_W)
    ) u_argmin (
        .vals (pm_q),
        .idx  (arg_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pm_q        <= pm_init();
            wr_ptr      <= '0;
            surv_valid  <= 1'b0;
            frame_end   <= 1'b0;
            best_valid  <= 1'b0;
            surv        <= '0;
            mem_address <= '0;
            best_idx    <= '0;
        end else if (flush) begin
            pm_q       <= pm_init();
            wr_ptr     <= '0;
            surv_valid <= 1'b0;
            frame_end  <= 1'b0;
            best_valid <= 1'b0;
        end else begin
            surv_valid <= in_valid;
            frame_end  <= in_valid && (wr_ptr == AW'(DEPTH - 1));
            best_valid <= frame_end;
            if (frame_end) begin
                best_idx <= arg_idx;
            end
            if (in_valid) begin
                pm_q        <= pm_d;
                surv        <= dec;
                mem_address <= wr_ptr;
                wr_ptr      <= wr_ptr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_path_metric_acs.sv
// Directed bench for path_metric_acs at K=3, BM_W=2, PM_W=8, DEPTH=8.
// Covers reset, single ACS, frame/argmin, flush, renorm or saturation.
module tb_path_metric_acs;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] bm;
    logic        surv_valid;
    logic [3:0]  surv;
    logic [2:0]  mem_address;
    logic        frame_end;
    logic        best_valid;
    logic [1:0]  best_idx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    path_metric_acs #(
        .K     (3),
        .BM_W  (2),
        .PM_W  (8),
        .DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .bm          (bm),
        .surv_valid  (surv_valid),
        .surv        (surv),
        .mem_address (mem_address),
        .frame_end   (frame_end),
        .best_valid  (best_valid),
        .best_idx    (best_idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pm(input string tag, input int e0, input int e1,
                          input int e2, input int e3);
        chk({tag, "_pm0"}, 32'(dut.pm_q[0]), 32'(e0));
        chk({tag, "_pm1"}, 32'(dut.pm_q[1]), 32'(e1));
        chk({tag, "_pm2"}, 32'(dut.pm_q[2]), 32'(e2));
        chk({tag, "_pm3"}, 32'(dut.pm_q[3]), 32'(e3));
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        bm = '0;
        step();
        rst = 1'b0;
        chk_pm("reset", 0, 64, 64, 64);
        chk("reset_sv", 32'(surv_valid), 0);
        chk("reset_addr", 32'(mem_address), 0);
        chk("reset_best", 32'(best_idx), 0);
        chk("reset_bv", 32'(best_valid), 0);
        chk("reset_fe", 32'(frame_end), 0);

        // Single ACS: bm[0]=2, others 0; state 1 is a 64/64 tie
        bm = 16'h0002;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk_pm("acs1", 2, 64, 0, 64);
        chk("acs1_surv", 32'(surv), 0);
        chk("acs1_sv", 32'(surv_valid), 1);
        chk("acs1_addr", 32'(mem_address), 0);
        step();
        chk("acs1_sv_drop", 32'(surv_valid), 0);

        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_pm("flush0", 0, 64, 64, 64);

        // Full frame of zero metrics, 9th symbol back-to-back
        bm = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("frm_addr", 32'(mem_address), 32'(i));
            chk("frm_fe", 32'(frame_end), 32'(i == 7));
        end
        step();
        chk("frm_bv", 32'(best_valid), 1);
        chk("frm_best", 32'(best_idx), 0);
        chk("frm_wrap", 32'(mem_address), 0);
        chk("frm_fe_off", 32'(frame_end), 0);
        chk_pm("frm", 0, 0, 0, 0);

        // Second frame ends with PM {3,2,1,1}: argmin tie -> 2
        for (int i = 1; i < 7; i++) begin
            step();
        end
        chk("frm2_bv_low", 32'(best_valid), 0);
        chk("frm2_addr6", 32'(mem_address), 6);
        bm = 16'b10_01_01_11_11_10_11_11;
        step();
        in_valid = 1'b0;
        bm = '0;
        chk("frm2_addr7", 32'(mem_address), 7);
        chk("frm2_fe", 32'(frame_end), 1);
        chk("frm2_surv", 32'(surv), 32'b0100);
        chk_pm("frm2", 3, 2, 1, 1);
        step();
        chk("frm2_bv", 32'(best_valid), 1);
        chk("frm2_best", 32'(best_idx), 2);
        chk("frm2_sv_low", 32'(surv_valid), 0);
        chk("frm2_surv_hold", 32'(surv), 32'b0100);
        step();
        chk("frm2_bv_pulse", 32'(best_valid), 0);
        chk("frm2_best_hold", 32'(best_idx), 2);

        // Flush colliding with a symbol at address 3
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        chk("fl_addr2", 32'(mem_address), 2);
        flush = 1'b1;
        bm = 16'h5555;
        step();
        flush = 1'b0;
        bm = '0;
        chk("fl_sv", 32'(surv_valid), 0);
        chk_pm("fl", 0, 64, 64, 64);
        step();
        chk("fl_next_addr", 32'(mem_address), 0);
        chk("fl_next_sv", 32'(surv_valid), 1);
        chk_pm("fl_next", 0, 64, 0, 64);

        // Flush during frame_end suppresses the best pulse
        for (int i = 1; i < 8; i++) begin
            step();
        end
        chk("sup_fe", 32'(frame_end), 1);
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sup_bv", 32'(best_valid), 0);
        chk("sup_best_hold", 32'(best_idx), 2);
        chk("sup_fe_clr", 32'(frame_end), 0);
        step();
        chk("sup_bv2", 32'(best_valid), 0);

        // All metrics 3: PMs equalise at 6 then climb by 3
        bm = 16'hFFFF;
        in_valid = 1'b1;
        repeat (42) step();
        chk_pm("ren42", 126, 126, 126, 126);
        step();
`ifdef PM_RENORM_EN
        chk_pm("ren43", 1, 1, 1, 1);
`else
        chk_pm("ren43", 129, 129, 129, 129);
`endif
        repeat (47) step();
`ifdef PM_RENORM_EN
        chk_pm("ren90", 14, 14, 14, 14);
`else
        chk_pm("ren90", 255, 255, 255, 255);
`endif

        // Reset dominates flush and in_valid
        rst = 1'b1;
        flush = 1'b1;
        step();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        chk_pm("rst2", 0, 64, 64, 64);
        chk("rst2_best", 32'(best_idx), 0);
        chk("rst2_addr", 32'(mem_address), 0);
        chk("rst2_surv", 32'(surv), 0);
        chk("rst2_sv", 32'(surv_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
